// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple-dual-port RAM with a per-lane write mask, a registered
// read port with a valid strobe, a selectable read-during-write mode and a
// multi-cycle clear sweep that empties the array without asserting reset.
//
// Parameters
//   ADDR_W : address width, DEPTH = 1 << ADDR_W words
//   DATA_W : word width (multiple of LANE_W)
//   LANE_W : mask lane width, NL = DATA_W / LANE_W lanes
//   BYPASS : 1 = same-address read-during-write returns merged new word,
//            0 = returns the pre-write word
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   wr_en/addr/data   : write request, address and data
//   wr_mask[NL-1:0]   : lane enables, bit i covers data[i*LANE_W +: LANE_W]
//   rd_en/rd_addr     : read request and address
//   rd_data, rd_valid : registered read data and one-cycle valid strobe
//   clr               : clear-sweep request
//   busy              : high while the clear sweep runs
module ram_dp_clr #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LANE_W = 4,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/LANE_W-1:0]   wr_mask,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       clr,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NL    = DATA_W / LANE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r;
  logic                busy_r;

  logic [DATA_W-1:0]   old_word_s;
  logic [DATA_W-1:0]   merged_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                idle_s;
  logic                wr_go_s;
  logic                rd_go_s;
  logic                collide_s;

  // Replace the enabled lanes of old_word with the matching lanes of new_word.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NL-1:0]     mask
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        res[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end else begin
        res[i*LANE_W +: LANE_W] = old_word[i*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

  assign idle_s     = (state_r == ST_IDLE);
  // A clear request on the same edge wins over the write, which is dropped.
  assign wr_go_s    = idle_s & wr_en & ~clr;
  assign rd_go_s    = idle_s & rd_en;
  assign old_word_s = mem_r[wr_addr];
  assign merged_s   = lane_merge(old_word_s, wr_data, wr_mask);
  assign collide_s  = wr_go_s & (wr_addr == rd_addr) & (BYPASS != 0);
  assign rd_word_s  = collide_s ? merged_s : mem_r[rd_addr];

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;

  // Control FSM, memory array, sweep pointer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_go_s) begin
            mem_r[wr_addr] <= merged_s;
          end
          if (rd_go_s) begin
            rd_data_r  <= rd_word_s;
            rd_valid_r <= 1'b1;
          end else begin
            rd_valid_r <= 1'b0;
          end
          if (clr) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            ptr_r   <= '0;
          end
        end
        ST_CLEAR: begin
          // One word per edge; the pointer wraps naturally after LAST_ADDR.
          mem_r[ptr_r] <= '0;
          ptr_r        <= ptr_r + 1'b1;
          rd_valid_r   <= 1'b0;
          if (ptr_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          ptr_r      <= '0;
          rd_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
module tb_ram_dp_clr;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int LW    = 4;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NL-1:0] wr_mask;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          clr;
  logic [DW-1:0] rd_data1, rd_data0;
  logic          rd_valid1, rd_valid0;
  logic          busy1, busy0;

  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .clr(clr), .busy(busy1));

  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(LW), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .clr(clr), .busy(busy0));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: observable memory contents, remaining busy cycles,
  // expected outputs for each bypass mode.
  logic [DW-1:0] mmem [DEPTH];
  int            busy_left;
  logic [DW-1:0] e_d1, e_d0;
  logic          e_v;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NL-1:0] wm;
    logic          re;
    logic [AW-1:0] ra;
    logic          cl;
    logic          ev;
    logic [DW-1:0] ed1;
    logic [DW-1:0] ed0;
    logic          eb;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [NL-1:0] m);
    logic [DW-1:0] bm;
    bm = '0;
    for (int i = 0; i < DW; i++) bm[i] = m[i / LW];
    return (new_w & bm) | (old_w & ~bm);
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check1("rd_valid_bypass", {31'd0, rd_valid1}, {31'd0, e_v});
    check1("rd_valid_nobyp",  {31'd0, rd_valid0}, {31'd0, e_v});
    check1("rd_data_bypass",  {24'd0, rd_data1},  {24'd0, e_d1});
    check1("rd_data_nobyp",   {24'd0, rd_data0},  {24'd0, e_d0});
    check1("busy_bypass",     {31'd0, busy1},     {31'd0, (busy_left > 0)});
    check1("busy_nobyp",      {31'd0, busy0},     {31'd0, (busy_left > 0)});
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    busy_left = 0;
    e_d1 = '0;
    e_d0 = '0;
    e_v  = 1'b0;
  endtask

  task automatic model_step();
    logic [DW-1:0] mg;
    mg = ref_merge(mmem[wr_addr], wr_data, wr_mask);
    if (busy_left > 0) begin
      busy_left--;
      e_v = 1'b0;
    end else begin
      if (rd_en) begin
        e_v  = 1'b1;
        e_d0 = mmem[rd_addr];
        e_d1 = (wr_en && !clr && wr_addr == rd_addr) ? mg : mmem[rd_addr];
      end else begin
        e_v = 1'b0;
      end
      if (clr) begin
        // Contents are unobservable during the sweep, so zero them at once.
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        busy_left = DEPTH;
      end else if (wr_en) begin
        mmem[wr_addr] = mg;
      end
    end
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_en = 1'b0; rd_addr = '0; clr = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] m);
    idle_in();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    cycle();
    idle_in();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    idle_in();
    rd_en = 1'b1; rd_addr = a;
    cycle();
    idle_in();
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) do_read(a[AW-1:0]);
    cycle();
  endtask

  task automatic fill_nonzero();
    for (int a = 0; a < DEPTH; a++)
      do_write(a[AW-1:0], 8'($urandom_range(1, 255)), 2'b11);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_in();
  endtask

  task automatic start_clear();
    idle_in();
    clr = 1'b1;
    cycle();
    idle_in();
  endtask

  int n;

  initial begin
    reset = 1'b1;
    idle_in();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Reset contents: every address reads zero with a one-cycle strobe.
    read_all();

    // Masked write and same-address read-during-write, hand-derived values.
    tbl[0] = '{1'b1, 4'd3, 8'hA5, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 4'd3, 8'h3C, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 8'h00, 2'b00, 1'b1, 4'd3, 1'b0, 1'b1, 8'hAC, 8'hAC, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 8'h00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 8'hAC, 8'hAC, 1'b0};
    tbl[4] = '{1'b1, 4'd7, 8'h11, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 8'hAC, 8'hAC, 1'b0};
    tbl[5] = '{1'b1, 4'd7, 8'h99, 2'b10, 1'b1, 4'd7, 1'b0, 1'b1, 8'h91, 8'h11, 1'b0};
    tbl[6] = '{1'b0, 4'd0, 8'h00, 2'b00, 1'b1, 4'd7, 1'b0, 1'b1, 8'h91, 8'h91, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 8'h00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 8'h91, 8'h91, 1'b0};
    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_mask = tbl[i].wm;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra; clr = tbl[i].cl;
      cycle();
      check1("tbl_valid_b1", {31'd0, rd_valid1}, {31'd0, tbl[i].ev});
      check1("tbl_data_b1",  {24'd0, rd_data1},  {24'd0, tbl[i].ed1});
      check1("tbl_data_b0",  {24'd0, rd_data0},  {24'd0, tbl[i].ed0});
      check1("tbl_busy",     {31'd0, busy1},     {31'd0, tbl[i].eb});
    end
    idle_in();

    // Asynchronous reset while rd_data is nonzero, then all addresses read zero.
    async_reset();
    read_all();

    // Clear sweep accepted with a concurrent write (dropped) and read (served).
    fill_nonzero();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; wr_mask = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd5; clr = 1'b1;
    cycle();
    idle_in();
    n = 0;
    while (busy1 && n < 40) begin
      cycle();
      n++;
    end
    check1("sweep_len", n, 16);
    read_all();

    // Requests issued during the sweep are ignored and do not stretch it.
    fill_nonzero();
    start_clear();
    n = 0;
    while (busy1 && n < 40) begin
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 8'($urandom);
      wr_mask = 2'($urandom); rd_en = 1'($urandom); rd_addr = 4'($urandom);
      clr = 1'($urandom);
      cycle();
      n++;
    end
    idle_in();
    check1("sweep_len_busy_req", n, 16);
    read_all();

    // Reset in the middle of a sweep, then normal operation resumes.
    fill_nonzero();
    start_clear();
    for (int i = 0; i < 8; i++) cycle();
    async_reset();
    check1("busy_after_reset", {31'd0, busy1}, 32'd0);
    do_write(4'd2, 8'h5A, 2'b11);
    read_all();
    check1("addr2_data_model", {24'd0, mmem[2]}, 32'h5A);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      wr_en   = 1'($urandom);
      rd_en   = 1'($urandom);
      wr_mask = 2'($urandom);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        wr_addr = 4'($urandom_range(0, 3));
        rd_addr = 4'($urandom_range(0, 3));
      end else begin
        wr_addr = 4'($urandom);
        rd_addr = 4'($urandom);
      end
      clr = ($urandom_range(0, 79) == 0);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 20; i++) cycle();
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
